// File: rtl/lin_pkg.sv
// Shared types and helpers for the LIN slave responder: FSM state
// encoding, the sync byte value, PID parity and the LIN checksum add.
package lin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_DELIM,
    ST_SYNC,
    ST_PID,
    ST_SPACE,
    ST_TX_BYTE,
    ST_TX_CKSUM
  } lin_state_e;

  localparam logic [7:0] SYNC_BYTE          = 8'h55;
  // Bit-counter value meaning "waiting for the start-bit falling edge".
  localparam logic [3:0] RX_WAIT_START      = 4'hF;
  localparam int         DELIM_TIMEOUT_BITS = 4;

  // Returns {P1, P0} for a 6-bit frame ID.
  function automatic logic [1:0] pid_parity(input logic [5:0] id);
    pid_parity = {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4]};
  endfunction

  // 8-bit add with the carry wrapped back into the LSB.
  function automatic logic [7:0] cksum_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    cksum_add = s[7:0] + {7'd0, s[8]};
  endfunction

endpackage

// File: rtl/lin_slave_responder_bit_timer.sv
// Bit-time down-counter shared by header reception and response
// transmission. restart_i makes the following cycle the first cycle of a
// new bit; mid_tick_o marks the sample point, end_tick_o the last cycle.
module lin_bit_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic mid_tick_o,
  output logic end_tick_o
);

  localparam int TW = $clog2(CLK_DIV) + 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Reload on restart or terminal count, otherwise count down.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart_i || (cnt_q == '0)) cnt_d = TW'(CLK_DIV - 1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= TW'(CLK_DIV - 1);
    else     cnt_q <= cnt_d;
  end

  assign mid_tick_o = (cnt_q == TW'(CLK_DIV - 1 - CLK_DIV / 2));
  assign end_tick_o = (cnt_q == '0);

endmodule

// File: rtl/lin_slave_responder.sv
// LIN slave responder: receives break/sync/PID, checks parity and, when the
// PID matches the armed slot, sends the data bytes and checksum with
// readback checking. Define LIN_ENHANCED_CKSUM_EN to seed the checksum with
// the PID byte (enhanced checksum); default is the classic checksum.
//
// state       | meaning
// IDLE        | bus idle, waiting for a dominant level
// BREAK       | counting dominant cycles of a candidate break
// DELIM       | break qualified, waiting for the sync start edge
// SYNC        | receiving the sync byte
// PID         | waiting for / receiving the PID byte
// SPACE       | recessive gap before the response
// TX_BYTE     | transmitting response data bytes
// TX_CKSUM    | transmitting the checksum byte
module lin_slave_responder
  import lin_pkg::*;
#(
  parameter int CLK_DIV         = 16,
  parameter int BREAK_MIN_BITS  = 11,
  parameter int MAX_BYTES       = 8,
  parameter int RESP_SPACE_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lin_rx,
  output logic                   lin_tx,
  output logic                   lin_de,
  input  logic                   resp_en,
  input  logic [5:0]             resp_id,
  input  logic [3:0]             resp_len,
  input  logic [8*MAX_BYTES-1:0] resp_data,
  output logic                   hdr_valid,
  output logic [5:0]             hdr_id,
  output logic                   resp_done,
  output logic [3:0]             err,
  output logic                   busy
);

  localparam int BRK_CYC = BREAK_MIN_BITS * CLK_DIV;
  localparam int BW      = $clog2(BRK_CYC + 1);

  lin_state_e             state_q;
  logic [BW-1:0]          brk_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             tx_sh_q;
  logic [7:0]             cksum_q;
  logic [3:0]             bytes_left_q;
  logic [8*MAX_BYTES-1:0] data_sh_q;
  logic                   rx_prev_q;
  logic                   lin_tx_q, lin_de_q, hdr_valid_q, resp_done_q;
  logic [5:0]             hdr_id_q;
  logic [3:0]             err_q;

  logic fall, restart, mid_tick, end_tick;

  lin_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .mid_tick_o(mid_tick),
    .end_tick_o(end_tick)
  );

  // Re-align the bit timer on entry to DELIM, on a start edge and on a glitch.
  always_comb begin
    fall    = rx_prev_q & ~lin_rx;
    restart = 1'b0;
    case (state_q)
      ST_BREAK: restart = lin_rx;
      ST_DELIM: restart = fall;
      ST_SYNC, ST_PID:
        restart = ((bit_cnt_q == RX_WAIT_START) && fall) ||
                  (mid_tick && (bit_cnt_q == 4'd0) && lin_rx);
      default: restart = 1'b0;
    endcase
  end

  // Header reception / response transmission FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      brk_cnt_q    <= '0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      tx_sh_q      <= 8'h00;
      cksum_q      <= 8'h00;
      bytes_left_q <= 4'd0;
      data_sh_q    <= '0;
      rx_prev_q    <= 1'b1;
      lin_tx_q     <= 1'b1;
      lin_de_q     <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_id_q     <= 6'd0;
      resp_done_q  <= 1'b0;
      err_q        <= 4'd0;
    end else begin
      rx_prev_q   <= lin_rx;
      hdr_valid_q <= 1'b0;
      resp_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!lin_rx) begin
            state_q   <= ST_BREAK;
            brk_cnt_q <= BW'(1);
          end
        end
        ST_BREAK: begin
          if (!lin_rx) begin
            if (brk_cnt_q != BW'(BRK_CYC)) brk_cnt_q <= brk_cnt_q + 1'b1;
          end else if (brk_cnt_q >= BW'(BRK_CYC)) begin
            state_q   <= ST_DELIM;
            bit_cnt_q <= 4'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DELIM: begin
          if (fall) begin
            state_q   <= ST_SYNC;
            bit_cnt_q <= 4'd0;
          end else if (end_tick) begin
            if (bit_cnt_q == 4'(DELIM_TIMEOUT_BITS - 1)) begin
              err_q[0] <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_SYNC, ST_PID: begin
          if (bit_cnt_q == RX_WAIT_START) begin
            if (fall) bit_cnt_q <= 4'd0;
          end else if (mid_tick) begin
            if (bit_cnt_q == 4'd0) begin
              if (lin_rx) state_q <= ST_DELIM;
              else        bit_cnt_q <= 4'd1;
            end else if (bit_cnt_q <= 4'd8) begin
              shift_q   <= {lin_rx, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (!lin_rx) begin
              err_q[0] <= 1'b1;
              state_q  <= ST_IDLE;
            end else if (state_q == ST_SYNC) begin
              if (shift_q != SYNC_BYTE) begin
                err_q[1] <= 1'b1;
                state_q  <= ST_IDLE;
              end else begin
                state_q   <= ST_PID;
                bit_cnt_q <= RX_WAIT_START;
              end
            end else if (pid_parity(shift_q[5:0]) != shift_q[7:6]) begin
              err_q[2] <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              hdr_valid_q  <= 1'b1;
              hdr_id_q     <= shift_q[5:0];
              data_sh_q    <= resp_data;
              bytes_left_q <= (resp_len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : resp_len;
`ifdef LIN_ENHANCED_CKSUM_EN
              cksum_q      <= shift_q;
`else
              cksum_q      <= 8'h00;
`endif
              bit_cnt_q    <= 4'd0;
              if (resp_en && (resp_id == shift_q[5:0]) && (resp_len != 4'd0))
                state_q <= ST_SPACE;
              else
                state_q <= ST_IDLE;
            end
          end
        end
        // First end tick closes the PID stop bit, then the space bits follow.
        ST_SPACE: begin
          if (end_tick) begin
            if (bit_cnt_q == 4'(RESP_SPACE_BITS)) begin
              tx_sh_q      <= data_sh_q[7:0];
              data_sh_q    <= data_sh_q >> 8;
              cksum_q      <= cksum_add(cksum_q, data_sh_q[7:0]);
              bytes_left_q <= bytes_left_q - 4'd1;
              lin_tx_q     <= 1'b0;
              lin_de_q     <= 1'b1;
              bit_cnt_q    <= 4'd0;
              state_q      <= ST_TX_BYTE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_TX_BYTE, ST_TX_CKSUM: begin
          if (mid_tick && (lin_rx != lin_tx_q)) begin
            err_q[3] <= 1'b1;
            lin_tx_q <= 1'b1;
            lin_de_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (end_tick) begin
            if (bit_cnt_q < 4'd8) begin
              lin_tx_q  <= tx_sh_q[0];
              tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              lin_tx_q  <= 1'b1;
              bit_cnt_q <= 4'd9;
            end else if ((state_q == ST_TX_BYTE) && (bytes_left_q != 4'd0)) begin
              tx_sh_q      <= data_sh_q[7:0];
              data_sh_q    <= data_sh_q >> 8;
              cksum_q      <= cksum_add(cksum_q, data_sh_q[7:0]);
              bytes_left_q <= bytes_left_q - 4'd1;
              lin_tx_q     <= 1'b0;
              bit_cnt_q    <= 4'd0;
            end else if (state_q == ST_TX_BYTE) begin
              tx_sh_q   <= ~cksum_q;
              lin_tx_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= ST_TX_CKSUM;
            end else begin
              lin_de_q    <= 1'b0;
              resp_done_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lin_tx    = lin_tx_q;
  assign lin_de    = lin_de_q;
  assign hdr_valid = hdr_valid_q;
  assign hdr_id    = hdr_id_q;
  assign resp_done = resp_done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lin_slave_responder.sv
// Scoreboard bench for lin_slave_responder: the main process drives LIN
// headers as bus master and queues expected header IDs and response bytes;
// independent monitors decode hdr_valid pulses and the transmitted bus
// frames and compare them against the queues.
module tb_lin_slave_responder;

  localparam int CLK_DIV = 16;

`ifdef LIN_ENHANCED_CKSUM_EN
  localparam logic [7:0] EXP_CK = 8'hC3;
`else
  localparam logic [7:0] EXP_CK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mst = 1'b1;
  logic        force_dom = 1'b0;
  logic        lin_rx, lin_tx, lin_de;
  logic        resp_en = 1'b0;
  logic [5:0]  resp_id = 6'h00;
  logic [3:0]  resp_len = 4'd0;
  logic [63:0] resp_data = 64'h0;
  logic        hdr_valid, resp_done, busy;
  logic [5:0]  hdr_id;
  logic [3:0]  err;

  int checks = 0;
  int failures = 0;
  int hdr_cnt = 0;
  int done_cnt = 0;
  logic de_seen = 1'b0;

  logic [7:0] exp_tx_q[$];
  logic [5:0] exp_hdr_q[$];

  always #5 clk = ~clk;

  // Wired-AND bus: master level, our driver when enabled, forced dominant.
  assign lin_rx = mst & (lin_de ? lin_tx : 1'b1) & ~force_dom;

  lin_slave_responder #(
    .CLK_DIV(CLK_DIV), .BREAK_MIN_BITS(11), .MAX_BYTES(8), .RESP_SPACE_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .lin_rx(lin_rx), .lin_tx(lin_tx), .lin_de(lin_de),
    .resp_en(resp_en), .resp_id(resp_id), .resp_len(resp_len), .resp_data(resp_data),
    .hdr_valid(hdr_valid), .hdr_id(hdr_id), .resp_done(resp_done), .err(err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bus(input logic lvl, input int cyc);
    mst = lvl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus(1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) bus(b[i], CLK_DIV);
    bus(1'b1, CLK_DIV);
  endtask

  task automatic send_header(input int brk_bits, input logic [7:0] sync, input logic [7:0] pid);
    bus(1'b0, CLK_DIV * brk_bits);
    bus(1'b1, CLK_DIV);
    send_byte(sync);
    send_byte(pid);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    de_seen = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic wait_de_rise(input string name);
    int n;
    n = 0;
    while (!lin_de && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, lin_de, 1'b1);
  endtask

  // Header monitor: every good-parity pulse must match a queued ID.
  always @(posedge clk) begin
    #1;
    if (resp_done) done_cnt++;
    if (lin_de) de_seen = 1'b1;
    if (hdr_valid) begin
      hdr_cnt++;
      if (exp_hdr_q.size() == 0) check("hdr_unexpected", exp_hdr_q.size(), 1);
      else check("hdr_id", hdr_id, exp_hdr_q.pop_front());
    end
  end

  // Bus monitor: decode 8N1 frames while the driver is enabled.
  initial begin : tx_mon
    logic       active, ok;
    logic [9:0] bits;
    forever begin
      @(posedge clk);
      #1;
      if (lin_de) begin
        active = 1'b1;
        while (active) begin
          ok = 1'b1;
          bits = '0;
          repeat (CLK_DIV / 2) @(posedge clk);
          #1;
          for (int i = 0; i < 10; i++) begin
            if (i > 0 && ok) begin
              repeat (CLK_DIV) @(posedge clk);
              #1;
            end
            if (ok) begin
              if (!lin_de) ok = 1'b0;
              else bits[i] = lin_tx;
            end
          end
          if (ok) begin
            check("tx_frame_start_stop", {bits[9], bits[0]}, 2'b10);
            if (exp_tx_q.size() == 0) check("tx_unexpected", exp_tx_q.size(), 1);
            else check("tx_byte", bits[8:1], exp_tx_q.pop_front());
            repeat (CLK_DIV / 2) @(posedge clk);
            #1;
            active = lin_de;
          end else begin
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : main
    int n, d0, h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {lin_tx, lin_de, hdr_valid, hdr_id, resp_done, err, busy},
          {1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0});
    rst = 1'b0;
    idle(5);

    // Good header, response disarmed.
    resp_en = 1'b0; resp_id = 6'h3C; resp_len = 4'd2; resp_data = 64'hAA55;
    h0 = hdr_cnt;
    exp_hdr_q.push_back(6'h3C);
    send_header(13, 8'h55, 8'h3C);
    idle(400);
    check("disarmed_hdr_pulses", hdr_cnt - h0, 1);
    check("disarmed_hdr_id", hdr_id, 6'h3C);
    check("disarmed_de_seen", de_seen, 1'b0);
    check("disarmed_err", err, 4'h0);

    // Classic/enhanced response; inputs changed after the header are ignored.
    do_reset();
    resp_en = 1'b1; resp_id = 6'h3C; resp_len = 4'd2; resp_data = 64'hAA55;
    d0 = done_cnt;
    exp_hdr_q.push_back(6'h3C);
    exp_tx_q.push_back(8'h55);
    exp_tx_q.push_back(8'hAA);
    exp_tx_q.push_back(EXP_CK);
    send_header(13, 8'h55, 8'h3C);
    resp_len = 4'd1; resp_data = 64'h1234; resp_en = 1'b0;
    n = 0;
    while (!lin_de && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_range("resp_space_cycles", n, 16, 18);
    n = 0;
    while (done_cnt == d0 && n < 700) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_done_pulses", done_cnt - d0, 1);
    idle(2);
    check("resp_end_de", lin_de, 1'b0);
    check("resp_end_busy", busy, 1'b0);
    check("resp_end_err", err, 4'h0);

    // Short low (9 bits) then sync/PID bytes: not a break.
    do_reset();
    h0 = hdr_cnt;
    bus(1'b0, CLK_DIV * 9);
    bus(1'b1, CLK_DIV);
    send_byte(8'h55);
    send_byte(8'h3C);
    idle(50);
    check("short_break_hdr", hdr_cnt - h0, 0);
    check("short_break_err", err, 4'h0);

    // Bad sync byte.
    do_reset();
    h0 = hdr_cnt;
    send_header(13, 8'h54, 8'h3C);
    idle(50);
    check("sync_err", err, 4'b0010);
    check("sync_err_hdr", hdr_cnt - h0, 0);

    // Bad PID parity.
    do_reset();
    h0 = hdr_cnt;
    send_header(13, 8'h55, 8'h3D);
    idle(50);
    check("parity_err", err, 4'b0100);
    check("parity_err_hdr", hdr_cnt - h0, 0);

    // Readback failure on bit 1 (recessive) of data byte 0xAA.
    do_reset();
    resp_en = 1'b1; resp_id = 6'h3C; resp_len = 4'd2; resp_data = 64'h55AA;
    d0 = done_cnt;
    exp_hdr_q.push_back(6'h3C);
    send_header(13, 8'h55, 8'h3C);
    wait_de_rise("bit_err_de_rise");
    idle(2 * CLK_DIV + 2);
    force_dom = 1'b1;
    n = 0;
    while (lin_de && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_range("bit_err_release_cycles", n, 6, 8);
    check("bit_err_tx_recessive", lin_tx, 1'b1);
    force_dom = 1'b0;
    check("bit_err_flag", err, 4'b1000);
    idle(400);
    check("bit_err_no_done", done_cnt - d0, 0);
    check("bit_err_busy", busy, 1'b0);

    // Reset during the checksum byte.
    do_reset();
    resp_en = 1'b1; resp_id = 6'h3C; resp_len = 4'd2; resp_data = 64'hAA55;
    d0 = done_cnt;
    exp_hdr_q.push_back(6'h3C);
    exp_tx_q.push_back(8'h55);
    exp_tx_q.push_back(8'hAA);
    send_header(13, 8'h55, 8'h3C);
    wait_de_rise("reset_mid_de_rise");
    idle(20 * CLK_DIV + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_outputs", {lin_tx, lin_de, busy, err}, {1'b1, 1'b0, 1'b0, 4'h0});
    rst = 1'b0;
    idle(300);
    check("reset_mid_no_done", done_cnt - d0, 0);

    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("hdr_queue_drained", exp_hdr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
